// File: rtl/reset_sequencer.sv
// reset_sequencer: multi-domain reset controller. It waits for a filtered
// PLL lock with no reset request, stretches the reset, and then releases the
// channels in index order with a fixed gap between them. Any fault restarts
// the sequence and records its cause.
module reset_sequencer #(
   parameter int unsigned CHANNELS       = 3,
   parameter int unsigned LOCK_FILTER    = 4,
   parameter int unsigned STRETCH_CYCLES = 4194303,
   parameter int unsigned STAGE_GAP      = 16,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned RESET_IN_LOW   = 1
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_lock,
   input  logic                i_reset_req,
   input  logic                i_sw_reset,
   output logic [CHANNELS-1:0] o_reset_out,
   output logic                o_ready,
   output logic [1:0]          o_cause
);

   localparam int unsigned MAX_LS  = (LOCK_FILTER > STRETCH_CYCLES) ? LOCK_FILTER : STRETCH_CYCLES;
   localparam int unsigned CNT_MAX = (MAX_LS > STAGE_GAP) ? MAX_LS : STAGE_GAP;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
   localparam int unsigned CH_W    = $clog2(CHANNELS) + 1;

   localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILTER - 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
   localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(CHANNELS - 1);

   // Raw level of reset_req that means "request active"
   localparam logic REQ_ACT = (RESET_IN_LOW != 0) ? 1'b0 : 1'b1;

   localparam logic [1:0] CAUSE_LOCK = 2'd1;
   localparam logic [1:0] CAUSE_EXT  = 2'd2;
   localparam logic [1:0] CAUSE_SW   = 2'd3;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic [SYNC_STAGES-1:0] r_req_sync;
   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [CH_W-1:0]        r_ch;
   logic [CHANNELS-1:0]    r_reset_out;
   logic                   r_ready;
   logic [1:0]             r_cause;

   logic                   w_lock_s;
   logic                   w_req_s;
   logic                   w_fault;
   state_t                 w_state_nxt;
   logic [CNT_W-1:0]       w_cnt_nxt;
   logic [CH_W-1:0]        w_ch_nxt;
   logic [CHANNELS-1:0]    w_reset_out_nxt;
   logic                   w_ready_nxt;
   logic [1:0]             w_cause_nxt;

   // Synchronise lock and reset_req; req flops come up holding the asserted level
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_lock_sync <= '0;
         r_req_sync  <= {SYNC_STAGES{REQ_ACT}};
      end else begin
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], i_lock};
         r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], i_reset_req};
      end
   end

   assign w_lock_s = r_lock_sync[SYNC_STAGES-1];
   assign w_req_s  = (r_req_sync[SYNC_STAGES-1] == REQ_ACT);
   assign w_fault  = !w_lock_s || w_req_s || i_sw_reset;

   // State, counters and registered outputs
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_HOLD;
         r_cnt       <= '0;
         r_ch        <= '0;
         r_reset_out <= {CHANNELS{1'b1}};
         r_ready     <= 1'b0;
         r_cause     <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_ch        <= w_ch_nxt;
         r_reset_out <= w_reset_out_nxt;
         r_ready     <= w_ready_nxt;
         r_cause     <= w_cause_nxt;
      end
   end

   // Next-state decision
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_HOLD: begin
            if (!w_fault && (r_cnt == FILT_LAST)) w_state_nxt = ST_STRETCH;
         end
         ST_STRETCH: begin
            if (w_fault)                         w_state_nxt = ST_HOLD;
            else if (r_cnt == STRETCH_LAST)      w_state_nxt = (CHANNELS == 1) ? ST_RUN : ST_RELEASE;
         end
         ST_RELEASE: begin
            if (w_fault)                                    w_state_nxt = ST_HOLD;
            else if ((r_cnt == GAP_LAST) && (r_ch == CH_LAST)) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_fault) w_state_nxt = ST_HOLD;
         end
         default: w_state_nxt = ST_HOLD;
      endcase
   end

   // Counter, channel and output next values
   always_comb begin
      w_cnt_nxt       = r_cnt;
      w_ch_nxt        = r_ch;
      w_reset_out_nxt = r_reset_out;
      w_ready_nxt     = r_ready;
      w_cause_nxt     = r_cause;
      if (w_state_nxt == ST_HOLD) begin
         w_reset_out_nxt = {CHANNELS{1'b1}};
         w_ready_nxt     = 1'b0;
         w_ch_nxt        = '0;
         if (r_state != ST_HOLD) begin
            // Cause is only recorded on entry into HOLD, lock loss first
            w_cnt_nxt = '0;
            if (!w_lock_s)    w_cause_nxt = CAUSE_LOCK;
            else if (w_req_s) w_cause_nxt = CAUSE_EXT;
            else              w_cause_nxt = CAUSE_SW;
         end else if (w_fault) begin
            w_cnt_nxt = '0;
         end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
         end
      end else begin
         unique case (r_state)
            ST_HOLD: begin
               w_cnt_nxt = '0;
            end
            ST_STRETCH: begin
               if (w_state_nxt != ST_STRETCH) begin
                  w_cnt_nxt          = '0;
                  w_ch_nxt           = CH_W'(1);
                  w_reset_out_nxt[0] = 1'b0;
                  if (w_state_nxt == ST_RUN) w_ready_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (r_cnt == GAP_LAST) begin
                  w_cnt_nxt = '0;
                  w_ch_nxt  = r_ch + CH_W'(1);
                  for (int i = 0; i < int'(CHANNELS); i++) begin
                     if (CH_W'(i) == r_ch) w_reset_out_nxt[i] = 1'b0;
                  end
                  if (w_state_nxt == ST_RUN) w_ready_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_cnt_nxt = r_cnt;
            end
         endcase
      end
   end

   assign o_reset_out = r_reset_out;
   assign o_ready     = r_ready;
   assign o_cause     = r_cause;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for reset_sequencer. Expected output
// snapshots are queued with the edge they belong to when stimulus is applied
// and compared on the falling clock edge after that rising edge.
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock;
   logic       req0;
   logic       req1;
   logic       sw;
   logic [2:0] ro0, ro1;
   logic       rdy0, rdy1;
   logic [1:0] cause0, cause1;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_err  = 0;

   typedef struct {
      int         cyc;
      int         dut;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   // Count rising edges; edge k has completed when cyc == k at the falling edge
   always @(posedge clk) cyc <= cyc + 1;

   reset_sequencer #(
      .CHANNELS(3), .LOCK_FILTER(4), .STRETCH_CYCLES(8),
      .STAGE_GAP(2), .SYNC_STAGES(2), .RESET_IN_LOW(1)
   ) u_dut_lo (
      .i_clock(clk), .i_reset(rst), .i_lock(lock), .i_reset_req(req0),
      .i_sw_reset(sw), .o_reset_out(ro0), .o_ready(rdy0), .o_cause(cause0)
   );

   reset_sequencer #(
      .CHANNELS(3), .LOCK_FILTER(4), .STRETCH_CYCLES(8),
      .STAGE_GAP(2), .SYNC_STAGES(2), .RESET_IN_LOW(0)
   ) u_dut_hi (
      .i_clock(clk), .i_reset(rst), .i_lock(lock), .i_reset_req(req1),
      .i_sw_reset(sw), .o_reset_out(ro1), .o_ready(rdy1), .o_cause(cause1)
   );

   function automatic logic [5:0] pk(input logic [2:0] ro, input logic rdy, input logic [1:0] c);
      return {ro, rdy, c};
   endfunction

   task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got reset_out=%b ready=%b cause=%0d, want reset_out=%b ready=%b cause=%0d",
                  tag, obs[5:3], obs[2], obs[1:0], exp[5:3], exp[2], exp[1:0]);
      end
   endtask

   task automatic push(input int c, input int d, input logic [5:0] v);
      exp_t e;
      e.cyc = c;
      e.dut = d;
      e.val = v;
      sb.push_back(e);
   endtask

   // Expected clean release sequence starting from edge base+1
   task automatic sched_release(input int b, input int d, input logic [1:0] c);
      push(b + 1,  d, pk(3'b111, 1'b0, c));
      push(b + 6,  d, pk(3'b111, 1'b0, c));
      push(b + 13, d, pk(3'b111, 1'b0, c));
      push(b + 14, d, pk(3'b110, 1'b0, c));
      push(b + 15, d, pk(3'b110, 1'b0, c));
      push(b + 16, d, pk(3'b100, 1'b0, c));
      push(b + 17, d, pk(3'b100, 1'b0, c));
      push(b + 18, d, pk(3'b000, 1'b1, c));
   endtask

   task automatic at_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Pop and compare every entry whose edge has been reached
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            if (sb[i].cyc < cyc)
               check_val($sformatf("late_dut%0d_e%0d", sb[i].dut, sb[i].cyc),
                         (sb[i].dut == 0) ? pk(ro0, rdy0, cause0) : pk(ro1, rdy1, cause1), sb[i].val);
            else
               check_val($sformatf("dut%0d_e%0d", sb[i].dut, sb[i].cyc),
                         (sb[i].dut == 0) ? pk(ro0, rdy0, cause0) : pk(ro1, rdy1, cause1), sb[i].val);
            sb.delete(i);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   initial begin
      int b, k, m, n1, n2, r, n, w;
      rst  = 1'b1;
      lock = 1'b1;
      req0 = 1'b1;
      req1 = 1'b0;
      sw   = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_state_lo", pk(ro0, rdy0, cause0), pk(3'b111, 1'b0, 2'd0));
      check_val("reset_state_hi", pk(ro1, rdy1, cause1), pk(3'b111, 1'b0, 2'd0));

      // Power-on release, both reset_req polarities
      b = cyc;
      sched_release(b, 0, 2'd0);
      sched_release(b, 1, 2'd0);
      rst = 1'b0;
      at_cyc(b + 20);

      // Filter glitch: lock_s low for the edge-5 sample
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      b = cyc;
      push(b + 8,  0, pk(3'b111, 1'b0, 2'd0));
      push(b + 16, 0, pk(3'b111, 1'b0, 2'd0));
      push(b + 17, 0, pk(3'b110, 1'b0, 2'd0));
      push(b + 19, 0, pk(3'b100, 1'b0, 2'd0));
      push(b + 21, 0, pk(3'b000, 1'b1, 2'd0));
      at_cyc(b + 2);
      lock = 1'b0;
      at_cyc(b + 3);
      lock = 1'b1;
      at_cyc(b + 24);

      // Lock loss in RUN, then recovery
      k = cyc;
      push(k + 2, 0, pk(3'b000, 1'b1, 2'd0));
      push(k + 3, 0, pk(3'b111, 1'b0, 2'd1));
      lock = 1'b0;
      at_cyc(k + 5);
      m = cyc;
      push(m + 13, 0, pk(3'b111, 1'b0, 2'd1));
      push(m + 14, 0, pk(3'b110, 1'b0, 2'd1));
      push(m + 16, 0, pk(3'b100, 1'b0, 2'd1));
      push(m + 18, 0, pk(3'b000, 1'b1, 2'd1));
      lock = 1'b1;
      at_cyc(m + 20);

      // Software reset in RUN, then again while reset_out is 110
      n1 = cyc + 1;
      n2 = n1 + 13;
      push(n1,      0, pk(3'b111, 1'b0, 2'd3));
      push(n1 + 11, 0, pk(3'b111, 1'b0, 2'd3));
      push(n1 + 12, 0, pk(3'b110, 1'b0, 2'd3));
      push(n2,      0, pk(3'b111, 1'b0, 2'd3));
      push(n2 + 11, 0, pk(3'b111, 1'b0, 2'd3));
      push(n2 + 12, 0, pk(3'b110, 1'b0, 2'd3));
      push(n2 + 14, 0, pk(3'b100, 1'b0, 2'd3));
      push(n2 + 16, 0, pk(3'b000, 1'b1, 2'd3));
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      at_cyc(n2 - 1);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      at_cyc(n2 + 18);

      // Lock loss and sw_reset seen on the same edge, then external request in HOLD
      k = cyc;
      r = k + 25;
      push(k + 2,  0, pk(3'b000, 1'b1, 2'd3));
      push(k + 3,  0, pk(3'b111, 1'b0, 2'd1));
      push(k + 10, 0, pk(3'b111, 1'b0, 2'd1));
      push(k + 20, 0, pk(3'b111, 1'b0, 2'd1));
      push(r,      0, pk(3'b111, 1'b0, 2'd1));
      push(r + 13, 0, pk(3'b111, 1'b0, 2'd1));
      push(r + 14, 0, pk(3'b110, 1'b0, 2'd1));
      push(r + 18, 0, pk(3'b000, 1'b1, 2'd1));
      lock = 1'b0;
      at_cyc(k + 2);
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      at_cyc(k + 5);
      req0 = 1'b0;
      lock = 1'b1;
      at_cyc(r);
      req0 = 1'b1;
      at_cyc(r + 20);

      // Async reset in the middle of STRETCH clears cause before the next edge
      n = cyc + 1;
      push(n,     0, pk(3'b111, 1'b0, 2'd3));
      push(n + 5, 0, pk(3'b111, 1'b0, 2'd3));
      sw = 1'b1;
      @(negedge clk);
      sw = 1'b0;
      at_cyc(n + 7);
      #2 rst = 1'b1;
      #1;
      check_val("async_rst_lo", pk(ro0, rdy0, cause0), pk(3'b111, 1'b0, 2'd0));
      check_val("async_rst_hi", pk(ro1, rdy1, cause1), pk(3'b111, 1'b0, 2'd0));
      @(negedge clk);
      b = cyc;
      sched_release(b, 0, 2'd0);
      sched_release(b, 1, 2'd0);
      rst = 1'b0;
      at_cyc(b + 20);

      w = 0;
      while (sb.size() > 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      check_val("sb_drain", 6'(sb.size()), 6'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised multi-domain reset controller that sits between the board clock/PLL and the core. It holds every reset output asserted until the PLL lock has been stable for a filter window and the external reset request is released. It then stretches the reset and releases the channels one at a time, in order, with a fixed gap between each. A software reset request, a lock loss or a board reset-button press restarts the whole sequence, and a status field records the cause of the last reset.

## Interface
- CHANNELS, 3: number of reset outputs, released in index order; ≥1
- LOCK_FILTER, 4: consecutive cycles of good lock with request inactive needed to leave HOLD; ≥1
- STRETCH_CYCLES, 4194303: cycles spent in STRETCH; ≥1
- STAGE_GAP, 16: cycles between release of channel i and channel i+1; ≥1
- SYNC_STAGES, 2: synchroniser depth on lock and reset_req; ≥2
- RESET_IN_LOW, 1: 1 means reset_req is active-low, 0 means active-high

- clock  in  1  single clock domain
- reset  in  1  asynchronous, active-high
- lock  in  1  PLL lock, asynchronous
- reset_req  in  1  board reset button, asynchronous, polarity set by RESET_IN_LOW
- sw_reset  in  1  synchronous one-cycle software/watchdog reset request
- reset_out  out  CHANNELS  active-high per-domain resets
- ready  out  1  high when all channels are released
- cause  out  2  last reset cause: 0 power-on, 1 lock loss, 2 external, 3 software

## Operation
- **Synchronisers.** lock and reset_req each pass through SYNC_STAGES flops, producing lock_s and req_s.
  - On reset, every lock synchroniser flop is 0.
  - On reset, every req synchroniser flop holds the asserted level.
  - req_s is normalised so that 1 means the request is active.
- **fault.** fault = !lock_s | req_s | sw_reset.
- **States.** HOLD, STRETCH, RELEASE, RUN.
- **HOLD**
  - All reset_out bits are 1 and ready is 0.
  - The filter counter increments on each edge where fault is 0, and clears on any edge where fault is 1.
  - On the edge where the counter would reach LOCK_FILTER, the block goes to STRETCH.
- **STRETCH**
  - The block stays for exactly STRETCH_CYCLES edges.
  - On the last of those edges it goes to RELEASE, clears reset_out[0] and zeroes the gap counter.
- **RELEASE**
  - Every STAGE_GAP edges, the next channel's reset_out bit clears.
  - The edge that clears reset_out[CHANNELS-1] also moves to RUN and sets ready.
  - If CHANNELS=1, the block goes STRETCH→RUN directly and ready rises together with reset_out[0] falling.
- **Fault outside HOLD.** A fault in STRETCH, RELEASE or RUN moves the block to HOLD on the same edge:
  - reset_out becomes all ones and ready becomes 0;
  - cause is written using the priority lock loss (1) > external (2) > software (3).
- **cause update rules**
  - cause is written only on a transition into HOLD from another state.
  - A fault while already in HOLD does not change cause; it only clears the filter counter.
- **Asynchronous reset**
  - At any time, reset asserting immediately forces HOLD, reset_out all ones, ready 0, cause 0, and all counters 0.
  - All outputs come straight from flops, so there are no combinational glitches.
- **Counters.** Widths are $clog2 of the relevant maximum parameter plus 1. Counters never wrap; each saturates or is reloaded on its state transition.

## Timing
- **Lock-loss / external fault latency.** From the edge at which the input is first sampled to reset_out all ones is SYNC_STAGES+1 edges.
- **sw_reset latency.** 1 edge.
- **Release time from a clean start.** With lock good and request inactive from the first edge after reset falls, reset_out[0] clears at edge SYNC_STAGES+LOCK_FILTER+STRETCH_CYCLES (edges counted from 1).
- **Release from sw_reset.** After sw_reset sampled at edge N, reset_out[0] clears at edge N+LOCK_FILTER+STRETCH_CYCLES.
- **Channel spacing.** reset_out[i] clears STAGE_GAP×i edges after reset_out[0]; ready rises on the same edge as the last channel.
- **Filter glitch.** A one-cycle lock drop seen on lock_s during HOLD restarts the filter; release is delayed by exactly the count already accumulated plus the drop length.

## Test plan
All scenarios use CHANNELS=3, LOCK_FILTER=4, STRETCH_CYCLES=8, STAGE_GAP=2, SYNC_STAGES=2, RESET_IN_LOW=1.

1. **Power-on.** Release reset with lock=1 and reset_req=1 → reset_out[0] clears at edge 14, [1] at edge 16, [2] at edge 18; ready=1 at edge 18; cause=0.
2. **Filter glitch.** Lock drops for one cycle so that lock_s is 0 at edge 5 → STRETCH entry moves from edge 6 to edge 9; reset_out[0] clears at edge 17.
3. **Lock loss in RUN.** lock→0 before edge N → reset_out=3'b111 and ready=0 at edge N+2; cause=1. When lock returns, the full sequence repeats.
4. **Software reset in RELEASE.** sw_reset at edge N while reset_out=3'b110 → 3'b111 at edge N; cause=3; reset_out[0] clears at edge N+12.
5. **Simultaneous faults.** lock_s falls on the same edge as sw_reset in RUN → cause=1, not 3.
   - Then assert reset_req low during HOLD → cause stays 1 and the filter is held at 0.
6. **Async reset mid-STRETCH.** Assert reset mid-STRETCH between edges → reset_out=3'b111 and cause=0 before the next edge.
   - Repeat scenario 1 with RESET_IN_LOW=0 and reset_req=0 → identical timing.
